// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the 32-bit custom ISA decode path:
//   - opcode constants and opcode-group upper bounds (groups are contiguous)
//   - 3-bit instruction class enum
//   - instruction field bit positions
//   - default link register index
//   - packed struct carrying the width-independent decoded fields
// Optional feature macro used by the decode path: DECODE_ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
package isa_pkg;

    // Opcode groups, inst[31:26]; each group ends at the listed opcode
    localparam logic [5:0] OPC_R_LAST = 6'b000011;
    localparam logic [5:0] OPC_I_LAST = 6'b001110;
    localparam logic [5:0] OPC_J_LAST = 6'b010011;
    localparam logic [5:0] OPC_S_LAST = 6'b010111;

    // Individual J-group opcodes
    localparam logic [5:0] OPC_JMP  = 6'b001111;
    localparam logic [5:0] OPC_JMP2 = 6'b010000;
    localparam logic [5:0] OPC_CALL = 6'b010001;
    localparam logic [5:0] OPC_JR   = 6'b010010;
    localparam logic [5:0] OPC_RET  = 6'b010011;

    // Field bit positions
    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 26;
    localparam int RD_MSB   = 25;
    localparam int RD_LSB   = 22;
    localparam int RS1_MSB  = 21;
    localparam int RS1_LSB  = 18;
    localparam int RS2_MSB  = 17;
    localparam int RS2_LSB  = 14;
    localparam int IMM_MSB  = 17;
    localparam int IMM_LSB  = 2;
    localparam int MODE_MSB = 1;
    localparam int MODE_LSB = 0;
    localparam int TGT_MSB  = 25;
    localparam int TGT_LSB  = 0;

    localparam logic [3:0] LINK_REG_DEF = 4'd15;

    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_J   = 3'd3,
        CLS_S   = 3'd4,
        CLS_ILL = 3'd5
    } inst_class_e;

    // Width-independent part of the decoded bundle; PC, immediate and
    // target are parameterised and travel alongside it.
    typedef struct packed {
        logic [5:0]  opcode;
        inst_class_e cls;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        rd_we;
        logic        rs1_en;
        logic        rs2_en;
        logic [1:0]  mode;
        logic        illegal;
    } dec_fields_t;

endpackage

// File: rtl/inst_decode_stage_if.sv
// -----------------------------------------------------------------------------
// inst_decode_stage_if
// Fetch-side and execute-side handshake bundle of the decode stage.
//   in_valid/in_ready, in_pc, in_inst      : fetch -> decode
//   out_valid/out_ready, out_*             : decode -> execute
// Modports:
//   master : the environment (drives in_*, out_ready)
//   slave  : the decode stage (drives in_ready, out_*)
// -----------------------------------------------------------------------------
interface inst_decode_stage_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [31:0]       in_inst;

    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [5:0]        out_opcode;
    logic [2:0]        out_class;
    logic [3:0]        out_rd;
    logic [3:0]        out_rs1;
    logic [3:0]        out_rs2;
    logic              out_rd_we;
    logic              out_rs1_en;
    logic              out_rs2_en;
    logic [DATA_W-1:0] out_imm;
    logic [1:0]        out_mode;
    logic [PC_W-1:0]   out_target;
    logic              out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_class,
               out_rd, out_rs1, out_rs2, out_rd_we, out_rs1_en, out_rs2_en,
               out_imm, out_mode, out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_class,
               out_rd, out_rs1, out_rs2, out_rd_we, out_rs1_en, out_rs2_en,
               out_imm, out_mode, out_target, out_illegal
    );
endinterface

// File: rtl/inst_field_decode.sv
// -----------------------------------------------------------------------------
// inst_field_decode
// Purely combinational instruction classifier / field extractor.
// Ports:
//   inst   in   32       instruction word
//   pc_hi  in   PC_W-26  upper PC bits that prefix the jump target
//   fields out  struct   opcode, class, register indices, flags, mode, illegal
//   imm    out  DATA_W   inst[17:2] sign-extended (I class only)
//   target out  PC_W     {pc_hi, inst[25:0]} (JMP/JMP2/CALL only)
// Fields not used by the decoded class are driven 0.
// Macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes report class ILL with the
// illegal flag set; otherwise they collapse to an all-zero NOP.
// -----------------------------------------------------------------------------
module inst_field_decode
    import isa_pkg::*;
#(
    parameter int         PC_W     = 32,
    parameter int         DATA_W   = 32,
    parameter logic [3:0] LINK_REG = LINK_REG_DEF
) (
    input  logic [31:0]      inst,
    input  logic [PC_W-27:0] pc_hi,
    output dec_fields_t      fields,
    output logic [DATA_W-1:0] imm,
    output logic [PC_W-1:0]  target
);

    logic [5:0]        opc;
    logic signed [15:0] imm_raw;

    assign opc     = inst[OPC_MSB:OPC_LSB];
    assign imm_raw = inst[IMM_MSB:IMM_LSB];

    always_comb begin
        fields        = '0;
        imm           = '0;
        target        = '0;
        fields.opcode = opc;

        if (opc <= OPC_R_LAST) begin
            fields.cls    = CLS_R;
            fields.rd     = inst[RD_MSB:RD_LSB];
            fields.rs1    = inst[RS1_MSB:RS1_LSB];
            fields.rs2    = inst[RS2_MSB:RS2_LSB];
            fields.rd_we  = 1'b1;
            fields.rs1_en = 1'b1;
            fields.rs2_en = 1'b1;
        end else if (opc <= OPC_I_LAST) begin
            fields.cls    = CLS_I;
            fields.rd     = inst[RD_MSB:RD_LSB];
            fields.rs1    = inst[RS1_MSB:RS1_LSB];
            fields.rd_we  = 1'b1;
            fields.rs1_en = 1'b1;
            fields.mode   = inst[MODE_MSB:MODE_LSB];
            imm           = DATA_W'(imm_raw);
        end else if (opc <= OPC_J_LAST) begin
            fields.cls = CLS_J;
            case (opc)
                OPC_JMP, OPC_JMP2: begin
                    target = {pc_hi, inst[TGT_MSB:TGT_LSB]};
                end
                OPC_CALL: begin
                    target       = {pc_hi, inst[TGT_MSB:TGT_LSB]};
                    fields.rd    = LINK_REG;
                    fields.rd_we = 1'b1;
                end
                OPC_JR: begin
                    // JR takes its source register from the rd slot
                    fields.rs1    = inst[RD_MSB:RD_LSB];
                    fields.rs1_en = 1'b1;
                end
                OPC_RET: begin
                    fields.rs1    = LINK_REG;
                    fields.rs1_en = 1'b1;
                end
                default: begin
                end
            endcase
        end else if (opc <= OPC_S_LAST) begin
            fields.cls   = CLS_S;
            fields.rd    = inst[RD_MSB:RD_LSB];
            fields.rd_we = 1'b1;
            // Odd S opcodes are the .M variants that also read rs1
            if (opc[0]) begin
                fields.rs1    = inst[RS1_MSB:RS1_LSB];
                fields.rs1_en = 1'b1;
            end
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            fields.cls     = CLS_ILL;
            fields.illegal = 1'b1;
`else
            fields.opcode  = '0;
`endif
        end
    end

endmodule

// File: rtl/inst_decode_stage.sv
// -----------------------------------------------------------------------------
// inst_decode_stage
// Registered decode stage between fetch and execute. Each accepted
// {pc, inst} word is decoded combinationally and captured either in the
// output register (OR) or, under back-pressure, in a single skid register
// (SK), giving one word per cycle with strict ordering.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high; clears OR, SK and the whole bundle
//   flush  in   empties OR and SK at the next edge; wins over everything
//   bus    slave modport of inst_decode_stage_if (handshakes + bundle)
// in_ready is the complement of the registered SK valid bit, forced low
// while reset is asserted.
// Macro DECODE_ILLEGAL_TRAP_EN selects trapping decode of illegal opcodes.
// -----------------------------------------------------------------------------
module inst_decode_stage
    import isa_pkg::*;
#(
    parameter int         PC_W     = 32,
    parameter int         DATA_W   = 32,
    parameter logic [3:0] LINK_REG = LINK_REG_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    inst_decode_stage_if.slave bus
);

    dec_fields_t       dec_fld;
    logic [DATA_W-1:0] dec_imm;
    logic [PC_W-1:0]   dec_target;

    inst_field_decode #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .LINK_REG (LINK_REG)
    ) u_field_decode (
        .inst   (bus.in_inst),
        .pc_hi  (bus.in_pc[PC_W-1:26]),
        .fields (dec_fld),
        .imm    (dec_imm),
        .target (dec_target)
    );

    // ---- stage p1: output register and skid register ----
    logic              or_vld_p1;
    logic [PC_W-1:0]   or_pc_p1;
    dec_fields_t       or_fld_p1;
    logic [DATA_W-1:0] or_imm_p1;
    logic [PC_W-1:0]   or_tgt_p1;

    logic              sk_vld_p1;
    logic [PC_W-1:0]   sk_pc_p1;
    dec_fields_t       sk_fld_p1;
    logic [DATA_W-1:0] sk_imm_p1;
    logic [PC_W-1:0]   sk_tgt_p1;

    logic accept;
    logic or_free;

    assign bus.in_ready = !sk_vld_p1 && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign or_free      = !or_vld_p1 || bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            or_vld_p1 <= 1'b0;
            or_pc_p1  <= '0;
            or_fld_p1 <= '0;
            or_imm_p1 <= '0;
            or_tgt_p1 <= '0;
            sk_vld_p1 <= 1'b0;
            sk_pc_p1  <= '0;
            sk_fld_p1 <= '0;
            sk_imm_p1 <= '0;
            sk_tgt_p1 <= '0;
        end else if (flush) begin
            or_vld_p1 <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else if (or_free) begin
            if (sk_vld_p1) begin
                // accept is impossible here: in_ready is low while SK is full
                or_vld_p1 <= 1'b1;
                or_pc_p1  <= sk_pc_p1;
                or_fld_p1 <= sk_fld_p1;
                or_imm_p1 <= sk_imm_p1;
                or_tgt_p1 <= sk_tgt_p1;
                sk_vld_p1 <= 1'b0;
            end else if (accept) begin
                or_vld_p1 <= 1'b1;
                or_pc_p1  <= bus.in_pc;
                or_fld_p1 <= dec_fld;
                or_imm_p1 <= dec_imm;
                or_tgt_p1 <= dec_target;
            end else begin
                or_vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            sk_vld_p1 <= 1'b1;
            sk_pc_p1  <= bus.in_pc;
            sk_fld_p1 <= dec_fld;
            sk_imm_p1 <= dec_imm;
            sk_tgt_p1 <= dec_target;
        end
    end

    assign bus.out_valid   = or_vld_p1;
    assign bus.out_pc      = or_pc_p1;
    assign bus.out_opcode  = or_fld_p1.opcode;
    assign bus.out_class   = or_fld_p1.cls;
    assign bus.out_rd      = or_fld_p1.rd;
    assign bus.out_rs1     = or_fld_p1.rs1;
    assign bus.out_rs2     = or_fld_p1.rs2;
    assign bus.out_rd_we   = or_fld_p1.rd_we;
    assign bus.out_rs1_en  = or_fld_p1.rs1_en;
    assign bus.out_rs2_en  = or_fld_p1.rs2_en;
    assign bus.out_imm     = or_imm_p1;
    assign bus.out_mode    = or_fld_p1.mode;
    assign bus.out_target  = or_tgt_p1;
    assign bus.out_illegal = or_fld_p1.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_stage
// Directed and randomized stimulus for inst_decode_stage, checked against a
// queue-based occupancy model and an arithmetic decode model. Honors the
// DECODE_ILLEGAL_TRAP_EN macro for the illegal-opcode expectations.
// -----------------------------------------------------------------------------
module tb_inst_decode_stage;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [2:0]  cls;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [2:0]  flags;   // {rd_we, rs1_en, rs2_en}
        logic [31:0] imm;
        logic [1:0]  mode;
        logic [31:0] target;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    exp_t model_q[$];
    logic [31:0] out_log[$];

    always #5 clk = ~clk;

    inst_decode_stage_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    inst_decode_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .LINK_REG(4'd15)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Decode model: classes from numeric opcode ranges.
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        int   op;
        int   v;
        op = int'(inst[31:26]);
        e.pc = pc; e.opcode = inst[31:26]; e.cls = 3'd0;
        e.rd = 4'd0; e.rs1 = 4'd0; e.rs2 = 4'd0; e.flags = 3'b000;
        e.imm = 32'd0; e.mode = 2'd0; e.target = 32'd0; e.illegal = 1'b0;
        if (op <= 3) begin
            e.cls = 3'd1; e.rd = inst[25:22]; e.rs1 = inst[21:18]; e.rs2 = inst[17:14];
            e.flags = 3'b111;
        end else if (op <= 14) begin
            e.cls = 3'd2; e.rd = inst[25:22]; e.rs1 = inst[21:18]; e.flags = 3'b110;
            v = int'(inst[17:2]);
            if (v >= 32768) v = v - 65536;
            e.imm = 32'(v);
            e.mode = inst[1:0];
        end else if (op <= 19) begin
            e.cls = 3'd3;
            if (op == 15 || op == 16 || op == 17)
                e.target = (pc & 32'hFC00_0000) | (inst & 32'h03FF_FFFF);
            if (op == 17) begin e.rd = 4'd15; e.flags = 3'b100; end
            if (op == 18) begin e.rs1 = inst[25:22]; e.flags = 3'b010; end
            if (op == 19) begin e.rs1 = 4'd15; e.flags = 3'b010; end
        end else if (op <= 23) begin
            e.cls = 3'd4; e.rd = inst[25:22]; e.flags = 3'b100;
            if (op == 21 || op == 23) begin e.rs1 = inst[21:18]; e.flags = 3'b110; end
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            e.cls = 3'd5; e.illegal = 1'b1;
`else
            e.opcode = 6'd0;
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = model_q.size();
        chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(!reset && n < 2));
        if (n > 0) begin
            chk("out_pc", 64'(bus.out_pc), 64'(model_q[0].pc));
            chk("out_opcode", 64'(bus.out_opcode), 64'(model_q[0].opcode));
            chk("out_class", 64'(bus.out_class), 64'(model_q[0].cls));
            chk("out_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}),
                64'({model_q[0].rd, model_q[0].rs1, model_q[0].rs2}));
            chk("out_flags", 64'({bus.out_rd_we, bus.out_rs1_en, bus.out_rs2_en}),
                64'(model_q[0].flags));
            chk("out_imm", 64'(bus.out_imm), 64'(model_q[0].imm));
            chk("out_mode", 64'(bus.out_mode), 64'(model_q[0].mode));
            chk("out_target", 64'(bus.out_target), 64'(model_q[0].target));
            chk("out_illegal", 64'(bus.out_illegal), 64'(model_q[0].illegal));
        end
    endtask

    // One clock: predict the edge from the driven inputs, then compare.
    task automatic tick();
        logic con;
        logic acc;
        con = (model_q.size() > 0) && bus.out_ready;
        acc = bus.in_valid && (model_q.size() < 2) && !reset && !flush;
        if (bus.out_valid && bus.out_ready) out_log.push_back(bus.out_pc);
        @(posedge clk);
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (con) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(bus.in_pc, bus.in_inst));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
    endtask

    task automatic drain();
        offer(1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic check_zero_bundle(input string tag);
        chk({tag, "_pc"}, 64'(bus.out_pc), 64'd0);
        chk({tag, "_fields"}, 64'({bus.out_opcode, bus.out_class, bus.out_rd, bus.out_rs1,
            bus.out_rs2, bus.out_rd_we, bus.out_rs1_en, bus.out_rs2_en, bus.out_mode,
            bus.out_illegal}), 64'd0);
        chk({tag, "_imm"}, 64'(bus.out_imm), 64'd0);
        chk({tag, "_target"}, 64'(bus.out_target), 64'd0);
    endtask

    logic [31:0] bp_pc[4];
    logic [31:0] w;
    int          idx;
    logic        dead_seen;

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        offer(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);

        // Reset behaviour
        tick();
        tick();
        chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        check_zero_bundle("rst");
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Directed R
        offer(1'b1, 32'h0000_1000, 32'h0190_C000, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("R_class", 64'(bus.out_class), 64'd1);
        chk("R_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'({4'd6, 4'd4, 4'd3}));
        chk("R_flags", 64'({bus.out_rd_we, bus.out_rs1_en, bus.out_rs2_en}), 64'd7);
        drain();

        // Directed I
        offer(1'b1, 32'h0000_1004, {6'b000100, 4'd2, 4'd5, 16'hFFFE, 2'b01}, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("I_class", 64'(bus.out_class), 64'd2);
        chk("I_imm", 64'(bus.out_imm), 64'hFFFF_FFFE);
        chk("I_mode", 64'(bus.out_mode), 64'd1);
        drain();

        // Directed CALL
        offer(1'b1, 32'hA400_0000, {6'b010001, 26'h000_0123}, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("CALL_target", 64'(bus.out_target), 64'hA400_0123);
        chk("CALL_rd", 64'({bus.out_rd, bus.out_rd_we}), 64'({4'd15, 1'b1}));
        drain();

        // Illegal opcode
        offer(1'b1, 32'h1234_5678, {6'b111111, 26'h3FF_FFFF}, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("ILL_pc", 64'(bus.out_pc), 64'h1234_5678);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ILL_class", 64'(bus.out_class), 64'd5);
        chk("ILL_flag", 64'(bus.out_illegal), 64'd1);
`else
        chk("ILL_class", 64'(bus.out_class), 64'd0);
        chk("ILL_flag", 64'(bus.out_illegal), 64'd0);
`endif
        drain();

        // Back-pressure: 4 words, out_ready low for 3 cycles
        for (int k = 0; k < 4; k++) bp_pc[k] = 32'h0000_2000 + 32'(k * 4);
        out_log.delete();
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            offer(1'b1, bp_pc[idx], {6'd1, 26'(idx + 1)}, 1'b0);
            if (model_q.size() < 2) idx++;
            tick();
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        for (int c = 0; c < 20 && (idx < 4 || model_q.size() > 0); c++) begin
            if (idx < 4) begin
                offer(1'b1, bp_pc[idx], {6'd1, 26'(idx + 1)}, 1'b1);
                if (model_q.size() < 2) idx++;
            end else begin
                offer(1'b0, 32'd0, 32'd0, 1'b1);
            end
            tick();
        end
        offer(1'b0, 32'd0, 32'd0, 1'b1);
        tick();
        chk("bp_count", 64'(out_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk("bp_order", 64'(out_log[k]), 64'(bp_pc[k]));

        // Flush with OR and SK full plus an offered word
        drain();
        offer(1'b1, 32'h0000_3000, 32'h0400_0000, 1'b0);
        tick();
        offer(1'b1, 32'h0000_3004, 32'h0400_0000, 1'b0);
        tick();
        chk("fl_sk_full", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        offer(1'b1, 32'hDEAD_0000, 32'h0400_0000, 1'b0);
        tick();
        flush = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        out_log.delete();
        offer(1'b0, 32'd0, 32'd0, 1'b1);
        for (int c = 0; c < 3; c++) tick();
        chk("fl_nothing_out", 64'(out_log.size()), 64'd0);

        // Reset mid-stream with SK full
        offer(1'b1, 32'h0000_4000, 32'h5000_0001, 1'b0);
        tick();
        offer(1'b1, 32'h0000_4004, 32'h5000_0001, 1'b0);
        tick();
        chk("mr_sk_full", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        offer(1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        check_zero_bundle("mr");

        // Randomized traffic
        dead_seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) w[31:26] = 6'($urandom_range(0, 23));
            offer($urandom_range(0, 3) != 0, $urandom, w, $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            tick();
        end
        flush = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Registered instruction-decode stage between fetch and execute for the 32-bit custom ISA. Accepts {PC, instruction} words through a valid/ready handshake and classifies each as R, I, J, S or illegal. Extracts register indices, the extended immediate, the mode and the jump target, and presents them as one registered bundle. A two-entry skid buffer provides full throughput under downstream back-pressure; a flush input squashes in-flight entries.

## Interface
- PC_W, 32, PC and jump-target width (≥ 27)
- DATA_W, 32, width of the extended immediate (≥ 16)
- LINK_REG, 4'd15, register index written by CALL and read by RET
- clk  in  1  clock; everything is on its rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  drop all buffered entries
- in_valid  in  1  fetch offers a word
- in_ready  out  1  stage can accept
- in_pc  in  PC_W  PC of the instruction
- in_inst  in  32  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  PC_W  forwarded PC
- out_opcode  out  6  inst[31:26]
- out_class  out  3  0 NOP, 1 R, 2 I, 3 J, 4 S, 5 ILL
- out_rd, out_rs1, out_rs2  out  4 each  register indices
- out_rd_we, out_rs1_en, out_rs2_en  out  1 each  use flags
- out_imm  out  DATA_W  inst[17:2], sign-extended
- out_mode  out  2  inst[1:0]
- out_target  out  PC_W  {in_pc[PC_W-1:26], inst[25:0]}
- out_illegal  out  1  illegal-opcode flag

## Operation
- Opcode groups are defined by inst[31:26]:
  - R: opcodes 000000–000011. rd = inst[25:22], rs1 = [21:18], rs2 = [17:14]. All three flags are set.
  - I: opcodes 000100–001110. rd and rs1 as for R; imm and mode are valid. rd_we = 1 and rs1_en = 1.
  - J:
    - 001111 JMP and 010000 JMP2: only target is valid.
    - 010001 CALL: target is valid; rd = LINK_REG, rd_we = 1.
    - 010010 JR: rs1 = inst[25:22], rs1_en = 1.
    - 010011 RET: rs1 = LINK_REG, rs1_en = 1.
  - S:
    - 010100 and 010110 (.1): rd = inst[25:22], rd_we = 1.
    - 010101 and 010111 (.M): additionally rs1 = inst[21:18], rs1_en = 1.
  - Every other opcode is illegal (see Configuration).
- Any field not used by the class is driven 0. Fields never hold a previous value.
- Decoding is combinational on the input word. The result is captured in the output register or in the skid register.
- Skid buffer:
  - Output register OR and skid register SK.
  - in_ready = !SK.valid, registered.
  - When OR is empty or being consumed, a new word goes to OR.
  - Otherwise the word goes to SK.
  - When OR is consumed and SK is full, SK moves to OR.
- Order is strictly preserved.

## Timing
- Latency: a word accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle while out_ready = 1.
- Reset:
  - out_valid = 0, SK empty, and every out_* bundle bit is 0.
  - in_ready = 0 while reset is high; it is 1 in the first cycle after reset deasserts.
- flush:
  - OR and SK are emptied at the next edge; out_valid = 0 and in_ready = 1 afterwards.
  - A word offered in the flush cycle is discarded.
  - flush takes priority over every other event.
- Simultaneous accept and consume with SK empty: OR is replaced and SK stays empty.
- Accept while OR is full and out_ready = 0: the word goes to SK and in_ready drops the next cycle.
- out_* is stable while out_valid && !out_ready.
- A reset asserted mid-stream discards everything, as flush does.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - Illegal opcodes give class 5 and out_illegal = 1.
  - Register and immediate fields are 0, all flags are 0.
  - out_pc is preserved so the trap handler can use it.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - Illegal opcodes decode as class 0 (NOP) with all fields 0.
  - out_illegal is tied to 0.

## Structure
- The shared package isa_pkg holds:
  - the opcode constants and the opcode-group bounds;
  - the class enum (3-bit typedef);
  - the field bit positions;
  - LINK_REG's default;
  - a packed struct for the decoded bundle.
- Sub-module inst_field_decode: purely combinational, inst + pc in, bundle out. The top level holds the OR/SK registers and the handshake.

## Test plan
- Directed decode, one word per class, checked field by field:
  - R: 0x0190_C000 (opcode 0) → class 1; rd 6, rs1 4, rs2 3; all flags 1.
  - I: inst = {6'b000100, 4'd2, 4'd5, 16'hFFFE, 2'b01} → class 2; imm 0xFFFF_FFFE, mode 1.
- CALL with inst[25:0] = 0x0000123, in_pc = 0xA400_0000 → target 0xA400_0123; rd 15, rd_we 1.
- Back-pressure: stream 4 words with out_ready = 0 for 3 cycles → in_ready drops after 2 accepts. Then release → all 4 words emerge in order with no loss or duplicate.
- Flush with OR and SK full plus in_valid = 1 → next cycle out_valid = 0 and in_ready = 1; the offered word never appears.
- Illegal opcode 6'b111111:
  - macro on → class 5, out_illegal 1, out_pc preserved;
  - macro off → class 0, out_illegal 0.
- Reset mid-stream with SK full → after reset, out_valid = 0, all outputs 0, in_ready = 1.
